// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The line is synchronised and edge-detected. The start bit is qualified at its
// midpoint, then each data bit and the stop bit are sampled at their midpoints.
// A good frame updates rx_data with a one-cycle rx_done pulse. A low stop bit
// gives a one-cycle frame_err pulse and leaves rx_data unchanged.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   // Clocks per bit, and clocks from the start edge to the start-bit midpoint.
   localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CNT = BAUD_CNT / 2;
   localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg_q;
   logic [7:0]       rx_data_q;
   logic             rx_done_q;
   logic             frame_err_q;
   logic             rx_busy_q;

   // Synchroniser stages plus the previous synchronised value used for edge detection.
   logic             rx_s1_q;
   logic             rx_s2_q;
   logic             rx_prev_q;

   logic             start_edge;
   logic [CNT_W-1:0] cnt_last;
   logic             baud_tick;

   // Two-flop synchroniser and edge register. All three reset to the idle (high) level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // A start edge is a 1->0 transition of the synchronised line.
   // The tick fires on the last count of the current interval.
   always_comb begin
      start_edge = rx_prev_q & ~rx_s2_q;
      cnt_last   = (state_q == START) ? HALF_LAST : BAUD_LAST;
      baud_tick  = (cnt_q == cnt_last);
      cnt_d      = cnt_q + CNT_W'(1);
   end

   // Receive FSM: owns the baud counter, the shift register and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         // Both strobes are single-cycle; they default low every clock.
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (start_edge) begin
                  state_q   <= START;
                  rx_busy_q <= 1'b1;
               end
            end
            START: begin
               if (baud_tick) begin
                  cnt_q <= '0;
                  if (!rx_s2_q) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end else begin
                     // The line was high again at the midpoint, so this was a glitch.
                     state_q   <= IDLE;
                     rx_busy_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DATA: begin
               if (baud_tick) begin
                  cnt_q              <= '0;
                  shreg_q[bit_idx_q] <= rx_s2_q;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STOP: begin
               if (baud_tick) begin
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                  rx_busy_q <= 1'b0;
                  if (rx_s2_q) begin
                     rx_data_q <= shreg_q;
                     rx_done_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q   <= IDLE;
               cnt_q     <= '0;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// A fast baud rate (16 clocks per bit) keeps the frames short. The expected
// bytes, frame errors and rx_data value come from a frame-level model: a frame
// with a high stop bit yields its byte, and a frame with a low stop bit yields
// one frame error.
module tb_uart_rx;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 3_125_000;
   localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
   // Clocks from the rx fall to rx_done: 9.5 bit periods plus 3 clocks.
   localparam int LAT       = (19 * BIT_CLKS) / 2 + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Monitor state
   logic [7:0] got_q[$];
   int         done_cnt      = 0;
   int         ferr_cnt      = 0;
   int         last_done_cyc = 0;
   bit         busy_at_done  = 1'b0;
   bit         busy_pre_done = 1'b0;
   bit         busy_seen     = 1'b0;
   bit         both_hi       = 1'b0;
   bit         dbl_pulse     = 1'b0;
   bit         prev_pulse    = 1'b0;
   bit         prev_busy     = 1'b0;

   // Model state
   logic [7:0] exp_q[$];
   int         exp_ferr = 0;
   logic [7:0] exp_data = 8'h00;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   // Sample the outputs 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rx_busy) busy_seen = 1'b1;
      if (rx_done && frame_err) both_hi = 1'b1;
      if ((rx_done || frame_err) && prev_pulse) dbl_pulse = 1'b1;
      prev_pulse = rx_done || frame_err;
      if (rx_done) begin
         got_q.push_back(rx_data);
         done_cnt++;
         last_done_cyc = cyc;
         busy_at_done  = rx_busy;
         busy_pre_done = prev_busy;
      end
      if (frame_err) ferr_cnt++;
      prev_busy = rx_busy;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      done_cnt  = 0;
      ferr_cnt  = 0;
      exp_ferr  = 0;
      busy_seen = 1'b0;
   endtask

   // Frame-level reference: the stop bit alone decides the outcome.
   task automatic model_frame(input logic [7:0] d, input logic stop_bit);
      if (stop_bit) begin
         exp_q.push_back(d);
         exp_data = d;
      end else begin
         exp_ferr++;
      end
   endtask

   // Drives one 8N1 frame starting at a negedge. The line is left at the stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int sc);
      rx = 1'b0;
      sc = cyc;
      tick(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(BIT_CLKS);
      end
      rx = stop_bit;
      tick(BIT_CLKS);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rx = 1'($urandom);
         checks++;
         if ({rx_data, rx_done, frame_err, rx_busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h done=%b ferr=%b busy=%b, expected all 0",
                     rx_data, rx_done, frame_err, rx_busy);
         end
      end
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      exp_data = 8'h00;
      clear_mon();
      tick(200);
      checks++;
      if (done_cnt !== 0 || ferr_cnt !== 0 || busy_seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got done=%0d ferr=%0d busy_seen=%b, expected 0 0 0",
                  done_cnt, ferr_cnt, busy_seen);
      end
   endtask

   task automatic test_single();
      int sc;
      clear_mon();
      send_frame(8'hA5, 1'b1, sc);
      model_frame(8'hA5, 1'b1);
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (done_cnt !== exp_q.size() || ferr_cnt !== exp_ferr) begin
         failures++;
         $display("FAIL single_counts: got done=%0d ferr=%0d, expected %0d %0d",
                  done_cnt, ferr_cnt, exp_q.size(), exp_ferr);
      end
      checks++;
      if (rx_data !== exp_data) begin
         failures++;
         $display("FAIL single_data: got %h expected %h", rx_data, exp_data);
      end
      checks++;
      if (last_done_cyc !== sc + LAT) begin
         failures++;
         $display("FAIL single_latency: got %0d clocks expected %0d", last_done_cyc - sc, LAT);
      end
      checks++;
      if (busy_pre_done !== 1'b1 || busy_at_done !== 1'b0) begin
         failures++;
         $display("FAIL single_busy_fall: got busy before=%b at done=%b, expected 1 0",
                  busy_pre_done, busy_at_done);
      end
   endtask

   task automatic test_back_to_back();
      int         sc;
      logic [7:0] fixed [3];
      logic [7:0] d;
      fixed[0] = 8'h5A;
      fixed[1] = 8'hFF;
      fixed[2] = 8'h00;
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         send_frame(fixed[i], 1'b1, sc);
         model_frame(fixed[i], 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1, sc);
         model_frame(d, 1'b1);
         tick($urandom_range(0, 3));
      end
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (done_cnt !== exp_q.size() || ferr_cnt !== 0) begin
         failures++;
         $display("FAIL b2b_counts: got done=%0d ferr=%0d, expected %0d 0",
                  done_cnt, ferr_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size()) begin
            failures++;
            $display("FAIL b2b_byte%0d: got none expected %h", i, exp_q[i]);
         end else if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      tick(BIT_CLKS / 4);
      rx = 1'b1;
      tick(3 * BIT_CLKS);
      checks++;
      if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
         failures++;
         $display("FAIL glitch_busy: got seen=%b now=%b, expected 1 0", busy_seen, rx_busy);
      end
      checks++;
      if (done_cnt !== 0 || ferr_cnt !== 0 || rx_data !== exp_data) begin
         failures++;
         $display("FAIL glitch_quiet: got done=%0d ferr=%0d data=%h, expected 0 0 %h",
                  done_cnt, ferr_cnt, rx_data, exp_data);
      end
   endtask

   task automatic test_frame_err();
      int sc;
      clear_mon();
      send_frame(8'h3C, 1'b0, sc);
      model_frame(8'h3C, 1'b0);
      // Hold a break; the receiver must not re-arm until the line rises and falls again.
      tick(3 * BIT_CLKS);
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (ferr_cnt !== exp_ferr || done_cnt !== 0) begin
         failures++;
         $display("FAIL ferr_counts: got ferr=%0d done=%0d, expected %0d 0",
                  ferr_cnt, done_cnt, exp_ferr);
      end
      checks++;
      if (rx_data !== exp_data) begin
         failures++;
         $display("FAIL ferr_data_held: got %h expected %h", rx_data, exp_data);
      end
      send_frame(8'hC3, 1'b1, sc);
      model_frame(8'hC3, 1'b1);
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (done_cnt !== 1 || rx_data !== exp_data) begin
         failures++;
         $display("FAIL ferr_recover: got done=%0d data=%h, expected 1 %h",
                  done_cnt, rx_data, exp_data);
      end
   endtask

   task automatic test_mid_reset();
      int         sc;
      logic [7:0] d;
      d = 8'hA5;
      clear_mon();
      rx = 1'b0;
      tick(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         tick(BIT_CLKS);
      end
      rx = d[4];
      tick(BIT_CLKS / 2);
      rst = 1'b0;
      exp_data = 8'h00;
      tick(1);
      checks++;
      if ({rx_data, rx_done, frame_err, rx_busy} !== 11'h000) begin
         failures++;
         $display("FAIL midreset_outputs: got data=%h done=%b ferr=%b busy=%b, expected all 0",
                  rx_data, rx_done, frame_err, rx_busy);
      end
      rx = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(11 * BIT_CLKS);
      checks++;
      if (done_cnt !== 0 || ferr_cnt !== 0 || rx_data !== exp_data) begin
         failures++;
         $display("FAIL midreset_quiet: got done=%0d ferr=%0d data=%h, expected 0 0 %h",
                  done_cnt, ferr_cnt, rx_data, exp_data);
      end
      send_frame(8'h81, 1'b1, sc);
      model_frame(8'h81, 1'b1);
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (done_cnt !== 1 || rx_data !== exp_data) begin
         failures++;
         $display("FAIL midreset_next: got done=%0d data=%h, expected 1 %h",
                  done_cnt, rx_data, exp_data);
      end
   endtask

   task automatic test_random();
      int         sc;
      logic [7:0] d;
      logic       stop_bit;
      logic       prev_bad;
      prev_bad = 1'b0;
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         d        = 8'($urandom);
         stop_bit = ($urandom_range(0, 3) != 0);
         send_frame(d, stop_bit, sc);
         model_frame(d, stop_bit);
         rx = 1'b1;
         // After a low stop bit the line must go high before the next start edge.
         tick(stop_bit ? $urandom_range(0, 3) : $urandom_range(2, 5));
         prev_bad = !stop_bit;
      end
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      checks++;
      if (done_cnt !== exp_q.size() || ferr_cnt !== exp_ferr) begin
         failures++;
         $display("FAIL rand_counts: got done=%0d ferr=%0d, expected %0d %0d (last bad=%b)",
                  done_cnt, ferr_cnt, exp_q.size(), exp_ferr, prev_bad);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size()) begin
            failures++;
            $display("FAIL rand_byte%0d: got none expected %h", i, exp_q[i]);
         end else if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (rx_data !== exp_data) begin
         failures++;
         $display("FAIL rand_data: got %h expected %h", rx_data, exp_data);
      end
   endtask

   task automatic test_pulse_rules();
      checks++;
      if (both_hi !== 1'b0 || dbl_pulse !== 1'b0) begin
         failures++;
         $display("FAIL pulse_rules: got overlap=%b long=%b, expected 0 0", both_hi, dbl_pulse);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      test_random();
      test_pulse_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of tx_uart in stage1/task6_uart.
- Deserialises the asynchronous `rx` line into bytes.
- Presents each good byte on `rx_data` with a one-cycle `rx_done` strobe.
- Flags stop-bit violations on `frame_err`; shares the 50 MHz system clock and baud settings with the transmitter.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- BAUD_CNT, CLK_FREQ/BAUD_RATE (5208, integer division), clocks per bit; derived, not overridden
- HALF_CNT, BAUD_CNT/2 (2604), clocks from the start edge to the start-bit midpoint; derived

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last correctly framed byte; held until the next good byte
- rx_done  output  1  one-cycle pulse: `rx_data` updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0.
  - Synchroniser flops and edge register = 1; state=IDLE; all counters = 0.
- Input conditioning:
  - `rx` passes through a 2-flop synchroniser, then one more flop for edge detection.
  - Start edge = previous synchronised value 1 and current 0.
  - All sampling uses the synchronised value. Fixed input latency is 2 clocks and is not compensated.
- Baud counter:
  - Counts 0..limit-1, then wraps to 0 and issues a sample tick.
  - Limit is HALF_CNT in START and BAUD_CNT in DATA/STOP.
  - Cleared on every state change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_busy=0. On start edge -> START, rx_busy=1.
  - START: at the tick (start-bit midpoint) sample the line.
    - Sample 0 -> DATA, bit index=0.
    - Sample 1 -> IDLE. This is glitch rejection: no flag, `rx_data` unchanged.
  - DATA: at each tick (midpoint of data bit n) load the sample into shift register bit n. Data is LSB first.
    - After bit 7 -> STOP.
  - STOP: at the tick sample the line.
    - Sample 1: rx_data <= shift register, rx_done=1 for exactly one cycle.
    - Sample 0: frame_err=1 for exactly one cycle; rx_data is not updated.
    - In both cases -> IDLE.
- Re-arming: a new frame requires a fresh 1->0 edge.
  - A line held low (break) after a framing error produces no further receptions until it returns high and falls again.
- Latency: rx_done/frame_err assert on the clock after the stop-bit midpoint tick.
  - This is about 9.5 bit periods plus 3 clocks after the falling edge on `rx`.
- rx_done and frame_err are never high together and are never high for more than one cycle.
- Back-to-back frames: a start edge arriving in the first cycle after returning to IDLE is accepted. No inter-frame idle is required beyond the stop bit.
- Reset mid-frame: reset aborts immediately. No rx_done/frame_err is produced for the partial frame, and the previous rx_data is cleared to 0.
- Reference model: widths are exact. The bit index is 3 bits; the baud counter is $clog2(BAUD_CNT) bits.

Test Plan:
- Reset: hold rst=0 for 100 ns with rx toggling -> all outputs 0 and state IDLE throughout. After release, rx idle high -> no rx_done for 1 ms.
- Single byte: drive 8'hA5 8N1 at a 104160 ns bit time -> exactly one rx_done pulse, rx_data=8'hA5, frame_err=0, rx_busy falls in the same cycle as rx_done.
- Back-to-back: 8'h5A immediately followed by 8'hFF, then 8'h00, each with a single stop bit -> three rx_done pulses with rx_data 8'h5A, 8'hFF, 8'h00 in order.
- Glitch: rx low for 1000 ns (< HALF_CNT clocks), then high -> rx_busy pulses, then returns to IDLE. No rx_done, no frame_err, rx_data unchanged.
- Framing error: send 8'h3C with the stop bit driven low, then hold the line high -> one frame_err pulse, no rx_done, rx_data keeps its prior value. A subsequent valid 8'hC3 is received correctly.
- Mid-frame reset: assert rst=0 during data bit 4 of 8'hA5, then release -> no pulses for that frame, rx_data=8'h00. The next frame 8'h81 is received correctly.
